// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Fetch-side sequencer feeding the special register file. Issues
// instruction-memory requests at pc_q, holds each fetched word for decode
// and, on retire, emits one-cycle PC (and optional LR) write strobes.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | first cycle after reset release
// REQ    | request valid at pc_q, waiting for imem_req_ready_i
// WAIT   | request accepted, waiting for response (timeout counter)
// HOLD   | instruction held for decode until instr_ready_i (retire)
// HALTED | no fetches issued, pc_q frozen until halt_i drops

module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,

  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,

  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        br_link_i,
  input  logic        halt_i,

  output logic        wr_pc_o,
  output logic [31:0] wr_pc_data_o,
  output logic        wr_lr_o,
  output logic [31:0] wr_lr_data_o,

  output logic        halted_o,
  output logic        fetch_err_o,
  output logic        align_err_o
);

  localparam logic [31:0] STEP    = 32'(PC_STEP);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [7:0]  cnt_q;
  logic        req_valid_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        wr_pc_q;
  logic [31:0] wr_pc_data_q;
  logic        wr_lr_q;
  logic [31:0] wr_lr_data_q;
  logic        halted_q;
  logic        fetch_err_q;
  logic        align_err_q;

  logic [31:0] br_next_d;
  logic [31:0] seq_next_d;
  logic [31:0] next_pc_d;
  logic [31:0] lr_d;
  logic        misalign_d;

  // Next-PC and return-address candidates; only consumed on a retire.
  always_comb begin
    br_next_d  = {br_target_i[31:2], 2'b00};
    seq_next_d = pc_q + STEP;
    next_pc_d  = br_taken_i ? br_next_d : seq_next_d;
    lr_d       = instr_pc_q + STEP;
    misalign_d = br_taken_i && (br_target_i[1:0] != 2'b00);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      cnt_q         <= 8'd0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      wr_pc_q       <= 1'b0;
      wr_pc_data_q  <= 32'd0;
      wr_lr_q       <= 1'b0;
      wr_lr_data_q  <= 32'd0;
      halted_q      <= 1'b0;
      fetch_err_q   <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      // Write strobes are single-cycle pulses.
      wr_pc_q <= 1'b0;
      wr_lr_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (halt_i) begin
            halted_q <= 1'b1;
            state_q  <= S_HALTED;
          end else begin
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end

        // halt_i is deliberately ignored here: an issued request must complete.
        S_REQ: begin
          if (imem_req_ready_i) begin
            req_valid_q <= 1'b0;
            cnt_q       <= 8'd0;
            state_q     <= S_WAIT;
          end
        end

        // A response on the timeout cycle takes priority over the re-issue.
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            instr_q       <= imem_rsp_data_i;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end else if (cnt_q == TO_LAST) begin
            fetch_err_q <= 1'b1;
            req_valid_q <= 1'b1;
            cnt_q       <= 8'd0;
            state_q     <= S_REQ;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_HOLD: begin
          if (instr_ready_i) begin
            instr_valid_q <= 1'b0;
            pc_q          <= next_pc_d;
            wr_pc_q       <= 1'b1;
            wr_pc_data_q  <= next_pc_d;
            if (misalign_d) begin
              align_err_q <= 1'b1;
            end
            if (br_taken_i && br_link_i) begin
              wr_lr_q      <= 1'b1;
              wr_lr_data_q <= lr_d;
            end
            if (halt_i) begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end

        S_HALTED: begin
          if (!halt_i) begin
            halted_q    <= 1'b0;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // pc_q only changes on a retire, so it doubles as the stable request address.
  assign imem_req_valid_o = req_valid_q;
  assign imem_addr_o      = pc_q;
  assign instr_valid_o    = instr_valid_q;
  assign instr_o          = instr_q;
  assign instr_pc_o       = instr_pc_q;
  assign wr_pc_o          = wr_pc_q;
  assign wr_pc_data_o     = wr_pc_data_q;
  assign wr_lr_o          = wr_lr_q;
  assign wr_lr_data_o     = wr_lr_data_q;
  assign halted_o         = halted_q;
  assign fetch_err_o      = fetch_err_q;
  assign align_err_o      = align_err_q;

endmodule
